// File: rtl/systolic_psum_accum_pkg.sv
// ============================================================================
// systolic_psum_accum_pkg : row-state encoding and default widths for psum path
// Rev 1.0
// ============================================================================
`default_nettype none

package systolic_psum_accum_pkg;

    localparam int ACC_WIDTH_DEF  = 40;
    localparam int PSUM_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ROW_EMPTY = 2'd0,
        ROW_ACCUM = 2'd1,
        ROW_READY = 2'd2
    } row_state_e;

endpackage

`default_nettype wire

// File: rtl/psum_valid_delay.sv
// ============================================================================
// psum_valid_delay : shift register aligning {valid, first, last} to psum rows
// Rev 1.0
// ============================================================================
`default_nettype none

module psum_valid_delay #(
    parameter int LATENCY = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    input  logic first_i,
    input  logic last_i,
    output logic valid_o,
    output logic first_o,
    output logic last_o
);

    logic [2:0] stage_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= 3'b000;
            end
        end else begin
            // Flags only mean something alongside a valid row.
            stage_q[0] <= valid_i ? {1'b1, first_i, last_i} : 3'b000;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign valid_o = stage_q[LATENCY-1][2];
    assign first_o = stage_q[LATENCY-1][1];
    assign last_o  = stage_q[LATENCY-1][0];

endmodule

`default_nettype wire

// File: rtl/systolic_psum_accum.sv
// ============================================================================
// systolic_psum_accum : K-tile psum accumulation buffer with in-order drain
// Rev 1.0
// ============================================================================
`default_nettype none

module systolic_psum_accum
    import systolic_psum_accum_pkg::*;
#(
    parameter int PSUM_WIDTH   = PSUM_WIDTH_DEF,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
    parameter int ARRAY_WIDTH  = 4,
    parameter int DEPTH        = 4,
    parameter int PIPE_LATENCY = 6,
    localparam int ROW_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         process_en,
    input  logic                         tile_first,
    input  logic                         tile_last,
    input  logic signed [PSUM_WIDTH-1:0] psum_in [ARRAY_WIDTH],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  acc_out [ARRAY_WIDTH],
    output logic [ROW_W-1:0]             out_row,
    output logic                         overflow
);

    logic dly_valid;
    logic dly_first;
    logic dly_last;

    psum_valid_delay #(
        .LATENCY (PIPE_LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (process_en),
        .first_i (tile_first),
        .last_i  (tile_last),
        .valid_o (dly_valid),
        .first_o (dly_first),
        .last_o  (dly_last)
    );

    row_state_e                  state_q [DEPTH];
    row_state_e                  state_d [DEPTH];
    logic signed [ACC_WIDTH-1:0] acc_q   [DEPTH][ARRAY_WIDTH];
    logic signed [ACC_WIDTH-1:0] acc_d   [DEPTH][ARRAY_WIDTH];
    logic [ROW_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [ROW_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic                        overflow_q, overflow_d;
    logic                        drain;
    row_state_e                  wr_state;

    function automatic logic [ROW_W-1:0] next_ptr(input logic [ROW_W-1:0] p);
        return (p == ROW_W'(DEPTH - 1)) ? '0 : p + ROW_W'(1);
    endfunction

    assign drain = (state_q[rd_ptr_q] == ROW_READY) && out_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        wr_state   = ROW_EMPTY;

        if (drain) begin
            state_d[rd_ptr_q] = ROW_EMPTY;
            rd_ptr_d          = next_ptr(rd_ptr_q);
        end

        // The write sees the post-drain state, so a same-cycle drain frees the row.
        if (dly_valid) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
            wr_state = state_d[wr_ptr_q];
            if (wr_state == ROW_READY) begin
                overflow_d = 1'b1;
            end else begin
                for (int c = 0; c < ARRAY_WIDTH; c++) begin
                    if (dly_first || (wr_state == ROW_EMPTY)) begin
                        acc_d[wr_ptr_q][c] = ACC_WIDTH'(psum_in[c]);
                    end else begin
                        acc_d[wr_ptr_q][c] = acc_q[wr_ptr_q][c] + ACC_WIDTH'(psum_in[c]);
                    end
                end
                state_d[wr_ptr_q] = dly_last ? ROW_READY : ROW_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                state_q[r] <= ROW_EMPTY;
                for (int c = 0; c < ARRAY_WIDTH; c++) begin
                    acc_q[r][c] <= '0;
                end
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = (state_q[rd_ptr_q] == ROW_READY);
    assign out_row   = rd_ptr_q;
    assign overflow  = overflow_q;

    for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_out_col
        assign acc_out[c] = acc_q[rd_ptr_q][c];
    end

endmodule

`default_nettype wire
